// File: rtl/demux_1to4_tdm.sv
// 1-to-4 time-division demultiplexer: one valid/ready input stream steered to four
// one-entry channel registers by a frame-aligned slot counter (TDM) or an explicit select.
module demux_1to4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_mode,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic             frame_done,
  output logic             sync_err,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d, eff_state_s;
  logic [1:0]       slot_q, slot_d;
  logic [7:0]       drop_q, drop_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic             mode_q;
  logic [3:0]       y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_q [4];

  logic [1:0]       tgt_s;
  logic             hunt_drop_s;
  logic             accept_s;
  logic [3:0]       load_s;

  // Routing and handshake: a 1->0 mode switch is treated as HUNT in that very cycle,
  // so the first TDM beat after direct mode is never steered by a stale slot count.
  always_comb begin
    eff_state_s = (mode_q && !sel_mode) ? ST_HUNT : state_q;
    hunt_drop_s = !sel_mode && (eff_state_s == ST_HUNT) && !in_sof;
    if (sel_mode) begin
      tgt_s = {s1, s0};
    end else if (in_sof) begin
      tgt_s = 2'd0;
    end else begin
      tgt_s = slot_q;
    end
    if (hunt_drop_s) begin
      in_ready = 1'b1;
    end else begin
      in_ready = !y_valid_q[tgt_s] || y_ready[tgt_s];
    end
    accept_s = in_valid && in_ready;
    load_s   = 4'b0000;
    if (accept_s && !hunt_drop_s) begin
      load_s[tgt_s] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

  // Frame tracker next state; frozen entirely in direct mode.
  always_comb begin
    state_d      = eff_state_s;
    slot_d       = slot_q;
    drop_d       = drop_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (!sel_mode && accept_s) begin
      case (eff_state_s)
        ST_HUNT: begin
          if (in_sof) begin
            state_d = ST_RUN;
            slot_d  = 2'd1;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end else begin
            drop_d = drop_q;
          end
        end
        ST_RUN: begin
          if (in_sof) begin
            slot_d     = 2'd1;
            sync_err_d = (slot_q != 2'd0);
          end else begin
            slot_d       = slot_q + 2'd1;
            frame_done_d = (slot_q == 2'd3);
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = eff_state_s;
    end
  end

  // Channel occupancy: a load wins over a same-cycle drain.
  always_comb begin
    y_valid_d = y_valid_q;
    for (int k = 0; k < 4; k++) begin
      if (load_s[k]) begin
        y_valid_d[k] = 1'b1;
      end else if (y_ready[k]) begin
        y_valid_d[k] = 1'b0;
      end else begin
        y_valid_d[k] = y_valid_q[k];
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      slot_q       <= 2'd0;
      drop_q       <= 8'd0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      mode_q       <= 1'b0;
      y_valid_q    <= 4'b0000;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      drop_q       <= drop_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      mode_q       <= sel_mode;
      y_valid_q    <= y_valid_d;
    end
  end

  // Channel data registers hold their last value after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load_s[k]) begin
          y_q[k] <= in_data;
        end
      end
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y_valid    = y_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Bench for demux_1to4_tdm: directed scenarios plus randomized traffic against a
// frame-level reference model.
module tb_demux_1to4_tdm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel_mode, s1, s0, in_valid, in_sof;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid, y_ready;
  logic       frame_done, sync_err;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_hunt;
  int         m_slot;
  bit         m_prev_mode;
  logic [7:0] m_y [4];
  logic [3:0] m_v;
  int         m_drop;
  bit         m_fd, m_se;
  bit         exp_ready, obs_ready;

  demux_1to4_tdm #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel_mode(sel_mode), .s1(s1), .s0(s0),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y_valid(y_valid), .y_ready(y_ready),
    .frame_done(frame_done), .sync_err(sync_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hunt = 1'b1; m_slot = 0; m_prev_mode = 1'b0; m_v = 4'b0000;
    m_drop = 0; m_fd = 1'b0; m_se = 1'b0;
    for (int k = 0; k < 4; k++) m_y[k] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sel_mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0; y_ready = 4'hF;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; samples in_ready before the edge and advances the model.
  task automatic step(input bit mode, input logic [1:0] sel, input bit sof, input bit valid,
                      input logic [7:0] data, input logic [3:0] yr);
    bit heff, dropm, acc;
    int t;
    @(negedge clk);
    sel_mode = mode; {s1, s0} = sel; in_sof = sof; in_valid = valid;
    in_data = data; y_ready = yr;
    #1;
    heff  = m_hunt || (m_prev_mode && !mode);
    dropm = !mode && heff && !sof;
    t = mode ? int'(sel) : (sof ? 0 : m_slot);
    exp_ready = dropm ? 1'b1 : (!m_v[t] || yr[t]);
    obs_ready = in_ready;
    acc = valid && exp_ready;
    @(posedge clk);
    #1;
    m_fd = 1'b0; m_se = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (acc && !dropm && k == t) begin
        m_y[k] = data; m_v[k] = 1'b1;
      end else if (yr[k]) begin
        m_v[k] = 1'b0;
      end
    end
    if (!mode) begin
      m_hunt = heff;
      if (acc) begin
        if (heff) begin
          if (sof) begin m_hunt = 1'b0; m_slot = 1; end
          else if (m_drop < 255) m_drop++;
        end else if (sof) begin
          m_se = (m_slot != 0); m_slot = 1;
        end else begin
          m_fd = (m_slot == 3); m_slot = (m_slot + 1) % 4;
        end
      end
    end
    m_prev_mode = mode;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel_mode = 1'b0; s1 = 1'b0; s0 = 1'b0; in_valid = 1'b0;
    in_sof = 1'b0; in_data = 8'h00; y_ready = 4'hF;
    model_reset();
    #3;
    checks++;
    if ({y0, y1, y2, y3, y_valid, frame_done, sync_err, drop_cnt} !== 46'd0) begin
      errors++; $display("FAIL reset_outputs: got y=%h %h %h %h v=%b fd=%b se=%b drop=%0d want all 0",
                         y0, y1, y2, y3, y_valid, frame_done, sync_err, drop_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_frame();
    do_reset();
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'h11, 4'hF);
    checks++;
    if (y0 !== 8'h11 || y_valid !== 4'b0001) begin
      errors++; $display("FAIL frame_slot0: got y0=%h v=%b want 11 0001", y0, y_valid);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h22, 4'hF);
    checks++;
    if (y1 !== 8'h22 || y_valid !== 4'b0010) begin
      errors++; $display("FAIL frame_slot1: got y1=%h v=%b want 22 0010", y1, y_valid);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h33, 4'hF);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h44, 4'hF);
    checks++;
    if ({y0, y1, y2, y3} !== 32'h11223344 || y_valid !== 4'b1000 || frame_done !== 1'b1) begin
      errors++; $display("FAIL frame_done: got y=%h%h%h%h v=%b fd=%b want 11223344 1000 1",
                         y0, y1, y2, y3, y_valid, frame_done);
    end
    step(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'hF);
    checks++;
    if (frame_done !== 1'b0 || y_valid !== 4'b0000) begin
      errors++; $display("FAIL frame_done_pulse: got fd=%b v=%b want 0 0000", frame_done, y_valid);
    end
  endtask

  task automatic test_hunt_drop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1, 8'($urandom), 4'hF);
      checks++;
      if (obs_ready !== 1'b1) begin
        errors++; $display("FAIL hunt_ready: got %b want 1", obs_ready);
      end
    end
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'hA0, 4'hF);
    checks++;
    if (drop_cnt !== 8'd3 || y0 !== 8'hA0 || y_valid !== 4'b0001) begin
      errors++; $display("FAIL hunt_lock: got drop=%0d y0=%h v=%b want 3 a0 0001", drop_cnt, y0, y_valid);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hB1, 4'hF);
    checks++;
    if (y1 !== 8'hB1 || drop_cnt !== 8'd3) begin
      errors++; $display("FAIL hunt_run: got y1=%h drop=%0d want b1 3", y1, drop_cnt);
    end
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b0, 2'd0, 1'b0, 1'b1, 8'($urandom), 4'($urandom));
    checks++;
    if (drop_cnt !== 8'd255 || y_valid !== 4'b0000) begin
      errors++; $display("FAIL drop_saturate: got drop=%0d v=%b want 255 0000", drop_cnt, y_valid);
    end
  endtask

  task automatic test_resync();
    do_reset();
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'h10, 4'hF);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h01, 4'hF);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h02, 4'hF);
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'h55, 4'hF);
    checks++;
    if (sync_err !== 1'b1 || frame_done !== 1'b0 || y0 !== 8'h55 || y_valid !== 4'b0001) begin
      errors++; $display("FAIL resync: got se=%b fd=%b y0=%h v=%b want 1 0 55 0001",
                         sync_err, frame_done, y0, y_valid);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h66, 4'hF);
    checks++;
    if (sync_err !== 1'b0 || y1 !== 8'h66 || y_valid !== 4'b0010) begin
      errors++; $display("FAIL resync_next: got se=%b y1=%h v=%b want 0 66 0010", sync_err, y1, y_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'hA1, 4'b1011);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hA2, 4'b1011);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hA3, 4'b1011);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hA4, 4'b1011);
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'hB1, 4'b1011);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hB2, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1, 8'hB3, 4'b1011);
      checks++;
      if (obs_ready !== 1'b0 || y2 !== 8'hA3 || y_valid[2] !== 1'b1) begin
        errors++; $display("FAIL bp_stall: got rdy=%b y2=%h v2=%b want 0 a3 1", obs_ready, y2, y_valid[2]);
      end
    end
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hB3, 4'hF);
    checks++;
    if (obs_ready !== 1'b1 || y2 !== 8'hB3 || y_valid[2] !== 1'b1) begin
      errors++; $display("FAIL bp_release: got rdy=%b y2=%h v2=%b want 1 b3 1", obs_ready, y2, y_valid[2]);
    end
    step(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'hF);
    checks++;
    if (y_valid !== 4'b0000 || y2 !== 8'hB3) begin
      errors++; $display("FAIL bp_drain: got v=%b y2=%h want 0000 b3", y_valid, y2);
    end
  endtask

  task automatic test_direct();
    do_reset();
    step(1'b1, 2'b10, 1'b1, 1'b1, 8'h7E, 4'hF);
    checks++;
    if (y2 !== 8'h7E || y_valid !== 4'b0100 || sync_err !== 1'b0 || frame_done !== 1'b0
        || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL direct: got y2=%h v=%b se=%b fd=%b drop=%0d want 7e 0100 0 0 0",
                         y2, y_valid, sync_err, frame_done, drop_cnt);
    end
    // lock a frame, detour through direct mode, then the first TDM beat must be hunted
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'hC0, 4'hF);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hC1, 4'hF);
    step(1'b1, 2'b11, 1'b0, 1'b1, 8'hD3, 4'hF);
    checks++;
    if (y3 !== 8'hD3 || y_valid !== 4'b1000) begin
      errors++; $display("FAIL direct_ch3: got y3=%h v=%b want d3 1000", y3, y_valid);
    end
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'hE2, 4'hF);
    checks++;
    if (drop_cnt !== 8'd1 || y_valid !== 4'b0000 || y2 !== 8'h7E) begin
      errors++; $display("FAIL mode_switch_hunt: got drop=%0d v=%b y2=%h want 1 0000 7e",
                         drop_cnt, y_valid, y2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'h21, 4'b0000);
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h22, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y0, y1, y2, y3, y_valid, frame_done, sync_err, drop_cnt} !== 46'd0) begin
      errors++; $display("FAIL async_reset: got y=%h %h %h %h v=%b fd=%b se=%b drop=%0d want all 0",
                         y0, y1, y2, y3, y_valid, frame_done, sync_err, drop_cnt);
    end
    model_reset();
    sel_mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0; y_ready = 4'hF;
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b1, 8'h23, 4'hF);
    checks++;
    if (drop_cnt !== 8'd1 || y_valid !== 4'b0000) begin
      errors++; $display("FAIL post_reset_hunt: got drop=%0d v=%b want 1 0000", drop_cnt, y_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) == 0), 2'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom));
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", i, obs_ready, exp_ready);
      end
      checks++;
      if ({y0, y1, y2, y3, y_valid, frame_done, sync_err, drop_cnt} !==
          {m_y[0], m_y[1], m_y[2], m_y[3], m_v, m_fd, m_se, 8'(m_drop)}) begin
        errors++; $display("FAIL rand_outputs cyc %0d: got y=%h%h%h%h v=%b fd=%b se=%b drop=%0d want y=%h%h%h%h v=%b fd=%b se=%b drop=%0d",
                           i, y0, y1, y2, y3, y_valid, frame_done, sync_err, drop_cnt,
                           m_y[0], m_y[1], m_y[2], m_y[3], m_v, m_fd, m_se, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hunt_drop();
    test_resync();
    test_backpressure();
    test_direct();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
